// File: rtl/truth_table_monitor.sv
// Passive checker: samples the DUT output once per stable input vector (SETTLE edges after a change) and scores it.
// Result pulses appear the cycle after the check edge; it never stalls anything.
module truth_table_monitor #(
    parameter int                  WIDTH    = 2,
    parameter int                  SETTLE   = 4,
    parameter logic [2**WIDTH-1:0] EXPECTED = 4'b1000,
    parameter int                  ERR_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      inputs,
    input  logic                  out,
    output logic                  checked,
    output logic                  mismatch,
    output logic [ERR_W-1:0]      err_count,
    output logic [2**WIDTH-1:0]   covered,
    output logic                  done,
    output logic                  first_fail_valid,
    output logic [WIDTH-1:0]      first_fail_idx,
    output logic                  first_fail_value
);

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    typedef enum logic {
        SETTLING,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] prev;
    logic [7:0]       cnt;
    logic [7:0]       cnt_nxt;
    logic             changed;
    logic             do_check;
    logic             miss;

    assign changed = (inputs != prev);
    assign miss    = (out != EXPECTED[inputs]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SETTLING;
            cnt   <= '0;
            prev  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            prev  <= inputs;
        end
    end

    // clear restarts settling exactly like a vector change, and swallows a coincident check
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_check  = 1'b0;
        if (clear || changed) begin
            state_nxt = SETTLING;
            cnt_nxt   = '0;
        end else if (state == SETTLING) begin
            if (cnt == SETTLE_LAST) begin
                do_check  = 1'b1;
                state_nxt = HOLD;
            end else begin
                cnt_nxt = cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checked          <= 1'b0;
            mismatch         <= 1'b0;
            err_count        <= '0;
            covered          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_value <= 1'b0;
        end else if (clear) begin
            checked          <= 1'b0;
            mismatch         <= 1'b0;
            err_count        <= '0;
            covered          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_value <= 1'b0;
        end else begin
            checked  <= do_check;
            mismatch <= do_check && miss;
            if (do_check) begin
                covered[inputs] <= 1'b1;
                if (miss) begin
                    if (err_count != ERR_MAX) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= inputs;
                        first_fail_value <= out;
                    end
                end
            end
        end
    end

    // covered only ever gains bits between clears, so this is naturally sticky
    assign done = &covered;

endmodule

// File: tb/tb_truth_table_monitor.sv
// Bench for truth_table_monitor: scoreboard of expected checks (due cycle, mismatch, vector) against observed pulses.
module tb_truth_table_monitor;

    localparam int SETTLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [1:0] inputs = 2'b00;
    logic       out = 1'b0;

    logic       checked, mismatch, done, ffv, ffval;
    logic [7:0] err_count;
    logic [3:0] covered;
    logic [1:0] ffidx;

    logic       checked_s, mismatch_s, done_s, ffv_s, ffval_s;
    logic [1:0] err_count_s;
    logic [3:0] covered_s;
    logic [1:0] ffidx_s;

    truth_table_monitor #(.WIDTH(2), .SETTLE(SETTLE), .EXPECTED(4'b1000), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .inputs(inputs), .out(out),
        .checked(checked), .mismatch(mismatch), .err_count(err_count), .covered(covered),
        .done(done), .first_fail_valid(ffv), .first_fail_idx(ffidx), .first_fail_value(ffval)
    );

    truth_table_monitor #(.WIDTH(2), .SETTLE(SETTLE), .EXPECTED(4'b1000), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .clear(clear), .inputs(inputs), .out(out),
        .checked(checked_s), .mismatch(mismatch_s), .err_count(err_count_s), .covered(covered_s),
        .done(done_s), .first_fail_valid(ffv_s), .first_fail_idx(ffidx_s), .first_fail_value(ffval_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic       mis;
        logic [1:0] idx;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] tt = 4'b1000;
    logic [1:0] cur = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (checked) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_check cyc=%0d got checked=1 want no check", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    n_vec++;
                    if (cyc !== e.due) begin
                        n_err++;
                        $display("FAIL check_timing vec=%0d got cyc=%0d want cyc=%0d", e.idx, cyc, e.due);
                    end
                    n_vec++;
                    if (mismatch !== e.mis) begin
                        n_err++;
                        $display("FAIL mismatch_flag vec=%0d got %b want %b", e.idx, mismatch, e.mis);
                    end
                    n_vec++;
                    if (covered[e.idx] !== 1'b1) begin
                        n_err++;
                        $display("FAIL covered_bit vec=%0d got covered=%b want bit set", e.idx, covered);
                    end
                end
            end else if (mismatch) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_mismatch cyc=%0d got mismatch=1 without checked", cyc);
            end
            if (checked_s !== checked || mismatch_s !== mismatch) begin
                n_vec++;
                n_err++;
                $display("FAIL sat_pulses cyc=%0d got %b%b want %b%b", cyc, checked_s, mismatch_s, checked, mismatch);
            end
        end
    end

    // reset and release with vector 0; the check of vector 0 is due SETTLE edges after release
    task automatic do_reset(input logic o, input bit push, input int hold);
        rst = 1'b1;
        clear = 1'b0;
        inputs = 2'b00;
        out = o;
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cur = 2'b00;
        if (push) q.push_back('{cyc + SETTLE, o != tt[0], 2'b00});
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [1:0] v, input logic o, input int hold);
        inputs = v;
        out = o;
        if (hold > SETTLE && v != cur) q.push_back('{cyc + 1 + SETTLE, o != tt[v], v});
        cur = v;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inputs = 2'b00;
        out = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({checked, mismatch, err_count, covered, done, ffv, ffidx, ffval} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %b/%b/%0d/%b/%b/%b want all zero", checked, mismatch, err_count, covered, done, ffv);
        end
        do_reset(1'b0, 1'b1, 10);
        n_vec++;
        if (covered !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_covered got %b want 0001", covered);
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL reset_missing_check got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_exhaustive();
        do_reset(1'b0, 1'b1, 10);
        apply(2'd1, 1'b0, 10);
        apply(2'd2, 1'b0, 10);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL exh_done_early got %b want 0", done);
        end
        apply(2'd3, 1'b1, 10);
        n_vec++;
        if (err_count !== 8'd0 || ffv !== 1'b0) begin
            n_err++;
            $display("FAIL exh_errors got err=%0d ffv=%b want 0/0", err_count, ffv);
        end
        n_vec++;
        if (done !== 1'b1 || covered !== 4'b1111) begin
            n_err++;
            $display("FAIL exh_done got done=%b covered=%b want 1/1111", done, covered);
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL exh_missing_check got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_fault();
        do_reset(1'b0, 1'b1, 10);
        apply(2'd1, 1'b0, 10);
        apply(2'd2, 1'b1, 10);
        apply(2'd3, 1'b1, 10);
        n_vec++;
        if (err_count !== 8'd1) begin
            n_err++;
            $display("FAIL fault_err_count got %0d want 1", err_count);
        end
        n_vec++;
        if (ffv !== 1'b1 || ffidx !== 2'd2 || ffval !== 1'b1) begin
            n_err++;
            $display("FAIL fault_first got v=%b idx=%0d val=%b want 1/2/1", ffv, ffidx, ffval);
        end
        n_vec++;
        if (done !== 1'b1 || q.size() != 0) begin
            n_err++;
            $display("FAIL fault_done got done=%b pending=%0d want 1/0", done, q.size());
        end
    endtask

    task automatic test_glitch();
        do_reset(1'b0, 1'b1, 10);
        apply(2'd1, 1'b0, 2);
        apply(2'd3, 1'b1, 10);
        n_vec++;
        if (covered !== 4'b1001) begin
            n_err++;
            $display("FAIL glitch_covered got %b want 1001", covered);
        end
        n_vec++;
        if (err_count !== 8'd0 || q.size() != 0) begin
            n_err++;
            $display("FAIL glitch_state got err=%0d pending=%0d want 0/0", err_count, q.size());
        end
    endtask

    task automatic test_saturation();
        do_reset(1'b1, 1'b1, 10);
        for (int i = 0; i < 5; i++) apply((i % 2 == 0) ? 2'd1 : 2'd0, 1'b1, 10);
        n_vec++;
        if (err_count_s !== 2'd3) begin
            n_err++;
            $display("FAIL sat_err_count got %0d want 3", err_count_s);
        end
        n_vec++;
        if (err_count !== 8'd6) begin
            n_err++;
            $display("FAIL wide_err_count got %0d want 6", err_count);
        end
        n_vec++;
        if (ffv_s !== 1'b1 || ffidx_s !== 2'd0 || ffval_s !== 1'b1 || ffidx !== 2'd0) begin
            n_err++;
            $display("FAIL sat_first got v=%b idx=%0d/%0d val=%b want 1/0/0/1", ffv_s, ffidx_s, ffidx, ffval_s);
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL sat_missing_check got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_clear_collision();
        do_reset(1'b1, 1'b1, 10);
        inputs = 2'd2;
        out = 1'b0;
        cur = 2'd2;
        repeat (4) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        q.push_back('{cyc + SETTLE, 1'b0, 2'd2});
        n_vec++;
        if (err_count !== 8'd0 || covered !== 4'b0000 || ffv !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL clear_stats got err=%0d cov=%b ffv=%b done=%b want zeros", err_count, covered, ffv, done);
        end
        repeat (10) @(posedge clk);
        #1;
        n_vec++;
        if (covered !== 4'b0100 || err_count !== 8'd0) begin
            n_err++;
            $display("FAIL clear_recheck got cov=%b err=%0d want 0100/0", covered, err_count);
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL clear_missing_check got %0d pending want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_fault();
        test_glitch();
        test_saturation();
        test_clear_collision();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
